// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//   Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
//   Each conversion takes W = 4*NDIG clock steps, one shift/correct per edge.
//   A conversion whose input holds any digit > 9 still runs the full W steps
//   (fixed latency), then reports bin_out = 0 with err = 1.
//
// Handshake:
//   start is sampled on a rising edge only while busy = 0; it is not queued.
//   busy is high from the edge after acceptance until the last step.
//   done is a one-cycle pulse that is never high while busy is high. bin_out
//   and err update together with done and hold until the next done or reset.
//
// Ports:
//   clk     : system clock, rising edge active
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, accepted when busy = 0
//   bcd_in  : packed BCD, [W-1:W-4] is the most significant digit
//   busy    : conversion in progress
//   done    : single-cycle result-valid pulse
//   bin_out : unsigned binary result
//   err     : input of the last conversion held an invalid digit
// -----------------------------------------------------------------------------
module bcd_to_bin #(
  parameter  int NDIG = 4,
  localparam int W    = 4 * NDIG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bcd_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] bin_out,
  output logic         err
);

  // Step counter has to reach W-1 (the index of the final step).
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // state_q is left as a plain named signal so checkers can bind to it.
  state_t           state_q;
  state_t           state_d;
  logic [2*W-1:0]   sr_q;
  logic [2*W-1:0]   sr_shift;
  logic [2*W-1:0]   sr_step;
  logic [CW-1:0]    cnt_q;
  logic             err_pend_q;
  logic             bad_digit;
  logic             accept;
  logic             last_step;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = CONV;
      CONV:    if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and step qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == CONV);
    accept    = (state_q == IDLE) && start;
    last_step = (state_q == CONV) && (cnt_q == CW'(W - 1));
  end

  // Any BCD digit above 9 poisons the whole conversion.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then every BCD field in the
  // upper half that became >= 8 had a ten carried into it from the digit
  // above (8 = 16/2), so it is pulled back down by 3 (16/2 - 10/2).
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_step  = sr_shift;
    for (int i = 0; i < NDIG; i++) begin
      if (sr_shift[W + 4*i +: 4] >= 4'd8) begin
        sr_step[W + 4*i +: 4] = sr_shift[W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      bin_out    <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sr_q       <= {bcd_in, {W{1'b0}}};
        cnt_q      <= '0;
        err_pend_q <= bad_digit;
      end else if (busy) begin
        sr_q  <= sr_step;
        cnt_q <= cnt_q + CW'(1);
        if (last_step) begin
          bin_out <= err_pend_q ? '0 : sr_step[W-1:0];
          err     <= err_pend_q;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin
//   Directed and random stimulus for bcd_to_bin (NDIG = 4). Expected results
//   come from a decimal-arithmetic reference model; outputs are sampled 1 time
//   unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bcd_in;
  logic         busy;
  logic         done;
  logic [W-1:0] bin_out;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected results for the random phase.
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  bcd_to_bin #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: plain decimal arithmetic on the digits.
  // ---------------------------------------------------------------------------
  function automatic void ref_conv(input logic [W-1:0] bcd,
                                   output logic [W-1:0] bin,
                                   output logic e);
    int unsigned value;
    int unsigned weight;
    int unsigned d;
    value  = 0;
    weight = 1;
    e      = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      d = (bcd >> (4 * i)) & 16'hF;
      if (d > 9) e = 1'b1;
      value  = value + d * weight;
      weight = weight * 10;
    end
    bin = e ? '0 : W'(value);
  endfunction

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic start_conv(input logic [W-1:0] bcd);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; also confirms that done
  // is never high with busy and that bin_out holds while converting.
  task automatic wait_done(input string tag, output int n);
    logic [W-1:0] held;
    int           glitches;
    held     = bin_out;
    glitches = 0;
    n        = 0;
    for (int k = 0; k < 40; k++) begin
      if (done && busy) glitches++;
      if (!done && bin_out !== held) glitches++;
      if (done) break;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_no_glitch"}, glitches, 0);
  endtask

  task automatic run_conv(input string tag, input logic [W-1:0] bcd);
    logic [W-1:0] eb;
    logic         ee;
    int           n;
    ref_conv(bcd, eb, ee);
    start_conv(bcd);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag, n);
    check({tag, "_latency"}, n, W);
    check({tag, "_bin"}, {16'd0, bin_out}, {16'd0, eb});
    check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           n;
    int           extra;
    logic [W-1:0] eb;
    logic         ee;
    logic [W-1:0] rb;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    #22;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bin",  {16'd0, bin_out}, 32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values
    run_conv("d1234", 16'h1234);
    check("d1234_const", {16'd0, bin_out}, 32'h04D2);
    run_conv("d9999", 16'h9999);
    check("d9999_const", {16'd0, bin_out}, 32'h270F);
    run_conv("d0000", 16'h0000);
    run_conv("d0001", 16'h0001);
    run_conv("d1000", 16'h1000);
    check("d1000_const", {16'd0, bin_out}, 32'h03E8);

    // Invalid digit, then a valid one
    run_conv("d12A4", 16'h12A4);
    check("d12A4_const", {15'd0, err, bin_out}, 32'h0001_0000);
    run_conv("d0050", 16'h0050);
    check("d0050_const", {15'd0, err, bin_out}, 32'h0000_0032);

    // start ignored while busy, bcd_in changes mid-run ignored
    start_conv(16'h0042);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bcd_in = 16'h9999;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 16'h1111;
    wait_done("ign", n);
    check("ign_latency", n + 5, W);
    check("ign_bin", {16'd0, bin_out}, 32'h002A);
    extra = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("ign_no_second_done", extra, 0);

    // Back-to-back: start during the done cycle
    start_conv(16'h0123);
    wait_done("b2b_a", n);
    check("b2b_a_bin", {16'd0, bin_out}, 32'h007B);
    start_conv(16'h0777);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done("b2b_b", n);
    check("b2b_gap", n + 1, W + 1);
    check("b2b_b_bin", {16'd0, bin_out}, 32'h0309);

    // Asynchronous reset mid-conversion
    start_conv(16'h5555);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_bin",  {16'd0, bin_out}, 32'd0);
    check("arst_err",  {31'd0, err}, 32'd0);
    #13;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    extra = 0;
    for (int k = 0; k < 24; k++) begin
      if (done || busy) extra++;
      @(posedge clk);
      #1;
    end
    check("arst_idle_after", extra, 0);
    run_conv("d0012", 16'h0012);
    check("d0012_const", {16'd0, bin_out}, 32'h000C);

    // Random phase through the scoreboard
    for (int t = 0; t < 30; t++) begin
      rb = '0;
      for (int i = 0; i < NDIG; i++) begin
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 5) == 0) begin
        rb[4 * $urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
      end
      ref_conv(rb, eb, ee);
      exp_q.push_back(eb);
      exp_err_q.push_back(ee);
      start_conv(rb);
      wait_done("rnd", n);
      check("rnd_latency", n, W);
      check("rnd_bin", {16'd0, bin_out}, {16'd0, exp_q.pop_front()});
      check("rnd_err", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
